// File: rtl/light_pattern_gen.sv
// Lamp-pattern producer for the reaction-timer game: arms a round, waits a
// pseudo-random number of ticks, then shows a non-zero pattern until clear or timeout.
module light_pattern_gen #(
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [15:0] DELAY_MIN  = 16'd1000,
    parameter int          DELAY_BITS = 8,
    parameter logic [15:0] SHOW_TICKS = 16'd2000
) (
    input  logic       cin,
    input  logic       resetn,
    input  logic       tick_en,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic       signal2,
    output logic       busy,
    output logic       false_start,
    output logic       missed
);

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] DLY_MASK = 8'((16'd1 << DELAY_BITS) - 16'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  lfsr_q;
    logic [3:0]  c1_q;
    logic [3:0]  c2_q;
    logic        signal2_q;
    logic        busy_q;
    logic        false_start_q;
    logic        missed_q;
    logic [15:0] delay_d;

    // Galois step with taps 0xB8: maximal length, never reaches zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    // Random wait length for a round armed on this edge.
    always_comb begin
        delay_d = DELAY_MIN + {8'h00, lfsr_q & DLY_MASK};
    end

    // Round sequencer; all outputs are registered here.
    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            lfsr_q        <= SEED_EFF;
            c1_q          <= 4'h0;
            c2_q          <= 4'h0;
            signal2_q     <= 1'b0;
            busy_q        <= 1'b0;
            false_start_q <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_next(lfsr_q);
            false_start_q <= 1'b0;
            missed_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q   <= delay_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // clear outranks the tick so an early press is always a false start
                    if (clear) begin
                        false_start_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (tick_en) begin
                        if (cnt_q == 16'd1) begin
                            c1_q      <= lfsr_q[3:0];
                            c2_q      <= lfsr_q[7:4];
                            signal2_q <= 1'b1;
                            cnt_q     <= SHOW_TICKS;
                            state_q   <= ST_SHOW;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (clear) begin
                        c1_q      <= 4'h0;
                        c2_q      <= 4'h0;
                        signal2_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (tick_en) begin
                        if (cnt_q == 16'd1) begin
                            missed_q  <= 1'b1;
                            c1_q      <= 4'h0;
                            c2_q      <= 4'h0;
                            signal2_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end
                default: begin
                    c1_q      <= 4'h0;
                    c2_q      <= 4'h0;
                    signal2_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign c1          = c1_q;
    assign c2          = c2_q;
    assign signal2     = signal2_q;
    assign busy        = busy_q;
    assign false_start = false_start_q;
    assign missed      = missed_q;

endmodule
